// File: rtl/spi_slave_if.sv
// Host-side register bus of spi_slave: TX/RX holding registers, status flags and mode pins.
interface spi_slave_if;
  logic        i_csn;
  logic [15:0] i_data;
  logic        i_wr;
  logic        i_rd;
  logic [15:0] o_data;
  logic        o_tx_ready;
  logic        o_rx_ready;
  logic        o_tx_error;
  logic        o_rx_error;
  logic        o_intr;
  logic        i_cpol;
  logic        i_cpha;
  logic        i_lsb_first;
  logic        i_clr_err;

  modport slave (
    input  i_csn, i_data, i_wr, i_rd, i_cpol, i_cpha, i_lsb_first, i_clr_err,
    output o_data, o_tx_ready, o_rx_ready, o_tx_error, o_rx_error, o_intr
  );

  modport master (
    output i_csn, i_data, i_wr, i_rd, i_cpol, i_cpha, i_lsb_first, i_clr_err,
    input  o_data, o_tx_ready, o_rx_ready, o_tx_error, o_rx_error, o_intr
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, 16-bit words, all modes; RX word visible 1 cycle after 16th sample, never stalls (underrun/overrun flagged).
// Optional LSB-first shifting under `SPI_SLAVE_LSB_FIRST_EN`; otherwise fixed MSB-first.
module spi_slave (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  spi_slave_if.slave bus,
  input  logic       i_sclk,
  input  logic       i_slave_csn,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nx;

  logic [1:0]  sclk_sync, csn_sync, mosi_sync, sync_vld;
  logic        sclk_q, csn_q, armed;
  logic        sclk_s, csn_s, mosi_s;
  logic [15:0] tx_hold, tx_sr, rx_sr, rx_next, data_q, load_word;
  logic [3:0]  bitcnt;
  logic        tx_full, tx_unf, rx_rdy, tx_err, rx_err, intr_q, miso_bit;
  logic        lsb_mode, rise, fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic        csn_fall, do_load, word_done, host_wr, host_rd;
  logic        rx_accept, tx_err_set, rx_err_set;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign lsb_mode = bus.i_lsb_first;
`else
  logic unused_lsb;
  assign lsb_mode   = 1'b0;
  assign unused_lsb = bus.i_lsb_first;
`endif

  function automatic logic [15:0] shl(input logic [15:0] w, input logic lsb);
    return lsb ? {1'b0, w[15:1]} : {w[14:0], 1'b0};
  endfunction

  function automatic logic head(input logic [15:0] w, input logic lsb);
    return lsb ? w[0] : w[15];
  endfunction

  // armed blocks a false CSN "fall" from the reset value until a real high level is seen
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      sclk_sync <= 2'b00;
      csn_sync  <= 2'b11;
      mosi_sync <= 2'b00;
      sync_vld  <= 2'b00;
      sclk_q    <= 1'b0;
      csn_q     <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], i_sclk};
      csn_sync  <= {csn_sync[0], i_slave_csn};
      mosi_sync <= {mosi_sync[0], i_mosi};
      sync_vld  <= {sync_vld[0], 1'b1};
      sclk_q    <= sclk_sync[1];
      csn_q     <= csn_sync[1];
      if (sync_vld[1] && csn_sync[1]) armed <= 1'b1;
    end
  end

  assign sclk_s      = sclk_sync[1];
  assign csn_s       = csn_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign rise        = sclk_s & ~sclk_q;
  assign fall        = ~sclk_s & sclk_q;
  assign lead_edge   = bus.i_cpol ? fall : rise;
  assign trail_edge  = bus.i_cpol ? rise : fall;
  assign sample_edge = (state == SHIFT) & (bus.i_cpha ? trail_edge : lead_edge);
  // cpha=0: the trailing edge of the previous word's last bit lands after the reload; skip it
  assign shift_edge  = (state == SHIFT) &
                       (bus.i_cpha ? lead_edge : (trail_edge & (bitcnt != 4'd0)));
  assign csn_fall    = armed & csn_q & ~csn_s;
  assign do_load     = (state == LOAD) & ~csn_s;
  assign word_done   = sample_edge & (bitcnt == 4'd15);
  assign rx_next     = lsb_mode ? {mosi_s, rx_sr[15:1]} : {rx_sr[14:0], mosi_s};
  assign load_word   = tx_full ? tx_hold : 16'h0000;
  assign host_wr     = bus.i_wr & ~bus.i_csn;
  assign host_rd     = bus.i_rd & ~bus.i_csn;
  assign rx_accept   = word_done & (~rx_rdy | host_rd);
  assign rx_err_set  = word_done & rx_rdy & ~host_rd;
  assign tx_err_set  = (host_wr & tx_full) | (sample_edge & tx_unf);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (csn_fall) state_nx = LOAD;
      LOAD:    state_nx = csn_s ? IDLE : SHIFT;
      SHIFT:   if (csn_s) state_nx = IDLE;
               else if (word_done) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      tx_sr    <= 16'h0000;
      rx_sr    <= 16'h0000;
      bitcnt   <= 4'd0;
      miso_bit <= 1'b0;
    end else begin
      if (do_load) begin
        bitcnt <= 4'd0;
        if (!bus.i_cpha) begin
          tx_sr    <= shl(load_word, lsb_mode);
          miso_bit <= head(load_word, lsb_mode);
        end else begin
          tx_sr    <= load_word;
          miso_bit <= 1'b0;
        end
      end
      if (sample_edge) begin
        rx_sr  <= rx_next;
        bitcnt <= bitcnt + 4'd1;
      end
      if (shift_edge) begin
        miso_bit <= head(tx_sr, lsb_mode);
        tx_sr    <= shl(tx_sr, lsb_mode);
      end
    end
  end

  // Underrun is only reported once a loaded-empty word actually starts clocking, so the
  // speculative reload after a final word does not flag an error when CSN then rises.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      tx_hold <= 16'h0000;
      tx_full <= 1'b0;
      tx_unf  <= 1'b0;
      data_q  <= 16'h0000;
      rx_rdy  <= 1'b0;
      tx_err  <= 1'b0;
      rx_err  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      if (do_load) begin
        tx_full <= 1'b0;
        tx_unf  <= ~tx_full;
      end else if (sample_edge) begin
        tx_unf  <= 1'b0;
      end
      if (host_wr && !tx_full) begin
        tx_hold <= bus.i_data;
        tx_full <= 1'b1;
      end
      if (rx_accept) begin
        data_q <= rx_next;
        rx_rdy <= 1'b1;
      end else if (host_rd) begin
        rx_rdy <= 1'b0;
      end
      if (bus.i_clr_err) begin
        tx_err <= 1'b0;
        rx_err <= 1'b0;
      end
      if (tx_err_set) tx_err <= 1'b1;
      if (rx_err_set) rx_err <= 1'b1;
      intr_q <= rx_rdy | tx_err | rx_err;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_tx_ready = ~tx_full;
  assign bus.o_rx_ready = rx_rdy;
  assign bus.o_tx_error = tx_err;
  assign bus.o_rx_error = rx_err;
  assign bus.o_intr     = intr_q;
  assign o_miso_oe      = ~csn_s;
  assign o_miso         = miso_bit & ~csn_s;
endmodule
